// File: rtl/rpn_kip_pkg.sv
// Shared constants, field layout and FSM state type for the KIP receive stage.
package rpn_kip_pkg;

  localparam logic [7:0] MSG_KIP_PUB    = 8'h10;
  localparam logic [7:0] MSG_KIP_ACK    = 8'h11;
  localparam logic [7:0] MSG_SEQ_REQ    = 8'h20;
  localparam logic [7:0] MSG_SEQ_COMMIT = 8'h21;

  localparam int unsigned MSG_TYPE_W   = 8;
  localparam int unsigned KIP_IP_W     = 32;
  localparam int unsigned KIP_PORT_W   = 16;

  // PUB beat layout: type, sender CTID, WAN seq, then payload up to the top bit
  localparam int unsigned PUB_TYPE_LSB = 0;
  localparam int unsigned PUB_CTID_LSB = 8;
  localparam int unsigned PUB_SEQ_LSB  = 24;
  localparam int unsigned PUB_PAY_LSB  = 56;

  // ACK beat layout mirrors the PUB header with no payload
  localparam int unsigned ACK_TYPE_LSB   = 0;
  localparam int unsigned ACK_CTID_LSB   = 8;
  localparam int unsigned ACK_SEQ_LSB    = 24;
  localparam int unsigned ACK_KEEP_BYTES = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_REQ_WNN,
    ST_WAIT_WNN,
    ST_FWD_CTRL,
    ST_COMMIT_WNN,
    ST_SEND_ACK
  } kip_rx_state_e;

endpackage

// File: rtl/rpn_kip_rx.sv
// KIP receive reliability stage: checks PUB sequence numbers against the WNN,
// delivers new payloads to control and ACKs new or duplicate PUBs.
module rpn_kip_rx
  import rpn_kip_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH = 512,
  parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int unsigned CTID_WIDTH      = 16,
  parameter int unsigned SEQ_WIDTH       = 32,
  parameter int unsigned KIP_TUSER_WIDTH = 64
) (
  input  logic                            i_clk,
  input  logic                            i_ap_rst_n,
  input  logic [CTID_WIDTH-1:0]           i_cluster_id,
  input  logic [15:0]                     i_KIP_port_number,

  input  logic                            from_nb_tvalid,
  output logic                            from_nb_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]      from_nb_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]      from_nb_tkeep,
  input  logic [KIP_TUSER_WIDTH-1:0]      from_nb_tuser,
  input  logic                            from_nb_tlast,

  output logic                            to_WNN_tvalid,
  input  logic                            to_WNN_tready,
  output logic [7:0]                      to_WNN_tdata,
  output logic [CTID_WIDTH-1:0]           to_WNN_tdest,

  input  logic                            from_WNN_tvalid,
  output logic                            from_WNN_tready,
  input  logic [SEQ_WIDTH-1:0]            from_WNN_tdata,

  output logic                            to_ctrl_tvalid,
  input  logic                            to_ctrl_tready,
  output logic [AXIS_DATA_WIDTH-1:0]      to_ctrl_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]      to_ctrl_tkeep,
  output logic [CTID_WIDTH+KIP_IP_W-1:0]  to_ctrl_tuser,
  output logic                            to_ctrl_tlast,

  output logic                            to_nb_KIP_tvalid,
  input  logic                            to_nb_KIP_tready,
  output logic [AXIS_DATA_WIDTH-1:0]      to_nb_KIP_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]      to_nb_KIP_tkeep,
  output logic [KIP_TUSER_WIDTH-1:0]      to_nb_KIP_tuser,
  output logic                            to_nb_KIP_tlast
);

  localparam int unsigned PAY_W       = AXIS_DATA_WIDTH - PUB_PAY_LSB;
  localparam int unsigned KEEP_SHIFT  = PUB_PAY_LSB / 8;

  kip_rx_state_e               state;
  logic [CTID_WIDTH-1:0]       ctid_q;
  logic [SEQ_WIDTH-1:0]        seq_q;
  logic [PAY_W-1:0]            pay_q;
  logic [AXIS_KEEP_WIDTH-1:0]  keep_q;
  logic [KIP_IP_W-1:0]         ip_q;

  logic [MSG_TYPE_W-1:0]       pub_type_c;
  logic [SEQ_WIDTH-1:0]        seq_diff_c;
  logic [AXIS_DATA_WIDTH-1:0]  ack_data_c;
  logic                        unused_tuser;

  assign pub_type_c   = from_nb_tdata[PUB_TYPE_LSB +: MSG_TYPE_W];
  assign seq_diff_c   = seq_q - from_WNN_tdata;
  assign unused_tuser = ^from_nb_tuser[KIP_TUSER_WIDTH-1:KIP_IP_W];

  // State and header capture; captured fields only change on an IDLE handshake
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      state  <= ST_IDLE;
      ctid_q <= '0;
      seq_q  <= '0;
      pay_q  <= '0;
      keep_q <= '0;
      ip_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (from_nb_tvalid) begin
            ctid_q <= from_nb_tdata[PUB_CTID_LSB +: CTID_WIDTH];
            seq_q  <= from_nb_tdata[PUB_SEQ_LSB +: SEQ_WIDTH];
            pay_q  <= from_nb_tdata[AXIS_DATA_WIDTH-1:PUB_PAY_LSB];
            keep_q <= from_nb_tkeep;
            ip_q   <= from_nb_tuser[KIP_IP_W-1:0];
            if (!from_nb_tlast)
              state <= ST_DRAIN;
            else if (pub_type_c == MSG_KIP_PUB)
              state <= ST_REQ_WNN;
          end
        end
        ST_DRAIN: begin
          if (from_nb_tvalid && from_nb_tlast)
            state <= ST_IDLE;
        end
        ST_REQ_WNN: begin
          if (to_WNN_tready)
            state <= ST_WAIT_WNN;
        end
        ST_WAIT_WNN: begin
          // Modular difference makes the 0xFFFFFFFF -> 0 wrap count as new
          if (from_WNN_tvalid) begin
            if (seq_diff_c == SEQ_WIDTH'(1))
              state <= ST_FWD_CTRL;
            else if (seq_diff_c == '0)
              state <= ST_SEND_ACK;
            else
              state <= ST_IDLE;
          end
        end
        ST_FWD_CTRL: begin
          if (to_ctrl_tready)
            state <= ST_COMMIT_WNN;
        end
        ST_COMMIT_WNN: begin
          if (to_WNN_tready)
            state <= ST_SEND_ACK;
        end
        ST_SEND_ACK: begin
          if (to_nb_KIP_tready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake signals decode the state register only
  assign from_nb_tready   = (state == ST_IDLE) || (state == ST_DRAIN);
  assign from_WNN_tready  = (state == ST_WAIT_WNN);
  assign to_WNN_tvalid    = (state == ST_REQ_WNN) || (state == ST_COMMIT_WNN);
  assign to_ctrl_tvalid   = (state == ST_FWD_CTRL);
  assign to_nb_KIP_tvalid = (state == ST_SEND_ACK);

  assign to_WNN_tdata = (state == ST_COMMIT_WNN) ? MSG_SEQ_COMMIT : MSG_SEQ_REQ;
  assign to_WNN_tdest = ctid_q;

  assign to_ctrl_tdata = AXIS_DATA_WIDTH'(pay_q);
  assign to_ctrl_tkeep = keep_q >> KEEP_SHIFT;
  assign to_ctrl_tuser = {ctid_q, ip_q};
  assign to_ctrl_tlast = 1'b1;

  // ACK formatter
  always_comb begin
    ack_data_c = '0;
    ack_data_c[ACK_TYPE_LSB +: MSG_TYPE_W] = MSG_KIP_ACK;
    ack_data_c[ACK_CTID_LSB +: CTID_WIDTH] = i_cluster_id;
    ack_data_c[ACK_SEQ_LSB +: SEQ_WIDTH]   = seq_q;
  end

  assign to_nb_KIP_tdata = ack_data_c;
  assign to_nb_KIP_tkeep = AXIS_KEEP_WIDTH'({ACK_KEEP_BYTES{1'b1}});
  assign to_nb_KIP_tuser = KIP_TUSER_WIDTH'({i_KIP_port_number, i_KIP_port_number, ip_q});
  assign to_nb_KIP_tlast = 1'b1;

endmodule

// File: tb/tb_rpn_kip_rx.sv
// Randomized bench for rpn_kip_rx with a behavioural WNN and expected-outcome model.
module tb_rpn_kip_rx;

  localparam logic [15:0] OWN_ID = 16'hC1A5;
  localparam logic [15:0] PORT   = 16'h1F90;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         nb_tvalid, nb_tready, nb_tlast;
  logic [511:0] nb_tdata;
  logic [63:0]  nb_tkeep, nb_tuser;
  logic         wq_tvalid, wq_tready;
  logic [7:0]   wq_tdata;
  logic [15:0]  wq_tdest;
  logic         wr_tvalid, wr_tready;
  logic [31:0]  wr_tdata;
  logic         c_tvalid, c_tready, c_tlast;
  logic [511:0] c_tdata;
  logic [63:0]  c_tkeep;
  logic [47:0]  c_tuser;
  logic         a_tvalid, a_tready, a_tlast;
  logic [511:0] a_tdata;
  logic [63:0]  a_tkeep, a_tuser;

  always #5 clk = ~clk;

  rpn_kip_rx dut (
    .i_clk(clk), .i_ap_rst_n(rst_n), .i_cluster_id(OWN_ID), .i_KIP_port_number(PORT),
    .from_nb_tvalid(nb_tvalid), .from_nb_tready(nb_tready), .from_nb_tdata(nb_tdata),
    .from_nb_tkeep(nb_tkeep), .from_nb_tuser(nb_tuser), .from_nb_tlast(nb_tlast),
    .to_WNN_tvalid(wq_tvalid), .to_WNN_tready(wq_tready), .to_WNN_tdata(wq_tdata),
    .to_WNN_tdest(wq_tdest),
    .from_WNN_tvalid(wr_tvalid), .from_WNN_tready(wr_tready), .from_WNN_tdata(wr_tdata),
    .to_ctrl_tvalid(c_tvalid), .to_ctrl_tready(c_tready), .to_ctrl_tdata(c_tdata),
    .to_ctrl_tkeep(c_tkeep), .to_ctrl_tuser(c_tuser), .to_ctrl_tlast(c_tlast),
    .to_nb_KIP_tvalid(a_tvalid), .to_nb_KIP_tready(a_tready), .to_nb_KIP_tdata(a_tdata),
    .to_nb_KIP_tkeep(a_tkeep), .to_nb_KIP_tuser(a_tuser), .to_nb_KIP_tlast(a_tlast)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] wnn_mem [8];

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic quiet_inputs();
    nb_tvalid = 1'b0; nb_tlast = 1'b0; wr_tvalid = 1'b0;
    wq_tready = 1'b0; c_tready = 1'b0; a_tready = 1'b0;
  endtask

  // One packet from the bridge plus servicing of WNN, control and ACK sinks
  task automatic run_txn(input logic [7:0] typ, input int ctid, input logic [31:0] seq,
                         input int nbeats, input int stall, input bit rst_mid);
    logic [511:0] beat, exp_ctrl, exp_ack;
    logic [63:0]  keep;
    logic [31:0]  ip, diff;
    bit exp_new, exp_dup, is_pub, pending, done;
    int n_req, n_cmt, n_ctrl, n_ack, c_vcyc, a_vcyc;

    diff    = seq - wnn_mem[ctid];
    is_pub  = (typ == 8'h10) && (nbeats == 1);
    exp_new = is_pub && (diff == 32'd1);
    exp_dup = is_pub && (diff == 32'd0);

    beat = rand512();
    beat[7:0] = typ; beat[23:8] = 16'(ctid); beat[55:24] = seq;
    keep = {$urandom, $urandom};
    ip   = $urandom;
    exp_ctrl = '0; exp_ctrl[455:0] = beat[511:56];
    exp_ack  = '0; exp_ack[7:0] = 8'h11; exp_ack[23:8] = OWN_ID; exp_ack[55:24] = seq;

    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      quiet_inputs();
      nb_tvalid = 1'b1;
      nb_tdata  = (b == 0) ? beat : rand512();
      nb_tkeep  = (b == 0) ? keep : {$urandom, $urandom};
      nb_tuser  = {$urandom, ip};
      nb_tlast  = (b == nbeats - 1);
      chk("nb_tready", 512'(nb_tready), 512'(1));
    end

    pending = 0; done = 0;
    n_req = 0; n_cmt = 0; n_ctrl = 0; n_ack = 0; c_vcyc = 0; a_vcyc = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      nb_tvalid = 1'b0; nb_tlast = 1'b0;
      wr_tvalid = 1'b0;
      if (pending) begin
        wr_tvalid = ($urandom_range(0, 3) != 0);
        wr_tdata  = wnn_mem[ctid];
      end else if ($urandom_range(0, 7) == 0) begin
        wr_tvalid = 1'b1;
        wr_tdata  = $urandom;
        chk("wnn_stray_ready", 512'(wr_tready), 512'(0));
      end
      wq_tready = ($urandom_range(0, 3) != 0);
      c_tready  = (c_vcyc >= stall) && ($urandom_range(0, 1) == 1);
      a_tready  = (a_vcyc >= stall) && ($urandom_range(0, 1) == 1);

      if (pending && wr_tvalid && wr_tready) pending = 0;

      if (wq_tvalid && wq_tready) begin
        chk("wnn_dest", 512'(wq_tdest), 512'(16'(ctid)));
        if (n_req == 0) begin
          chk("wnn_req_type", 512'(wq_tdata), 512'(8'h20));
          n_req++;
          pending = 1;
        end else begin
          chk("wnn_commit_type", 512'(wq_tdata), 512'(8'h21));
          n_cmt++;
          wnn_mem[ctid] = wnn_mem[ctid] + 32'd1;
        end
      end

      if (c_tvalid) begin
        if (rst_mid) begin
          rst_n = 1'b0;
          #1;
          chk("rst_ctrl_valid", 512'(c_tvalid), 512'(0));
          chk("rst_wnn_valid", 512'(wq_tvalid), 512'(0));
          chk("rst_ack_valid", 512'(a_tvalid), 512'(0));
          chk("rst_nb_ready", 512'(nb_tready), 512'(1));
          chk("rst_wnn_ready", 512'(wr_tready), 512'(0));
          quiet_inputs();
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        c_vcyc++;
        chk("ctrl_data", c_tdata, exp_ctrl);
        chk("ctrl_keep", 512'(c_tkeep), 512'(keep >> 7));
        chk("ctrl_user", 512'(c_tuser), 512'({16'(ctid), ip}));
        chk("ctrl_last", 512'(c_tlast), 512'(1));
        if (c_tready) n_ctrl++;
      end

      if (a_tvalid) begin
        a_vcyc++;
        chk("ack_data", a_tdata, exp_ack);
        chk("ack_keep", 512'(a_tkeep), 512'(64'h7F));
        chk("ack_user", 512'(a_tuser), 512'({PORT, PORT, ip}));
        chk("ack_last", 512'(a_tlast), 512'(1));
        if (a_tready) n_ack++;
      end

      if ((exp_new || exp_dup) ? (n_ack > 0) : (cyc >= 24)) done = 1;
    end

    chk("req_count", 512'(n_req), 512'(is_pub ? 1 : 0));
    chk("ctrl_count", 512'(n_ctrl), 512'(exp_new ? 1 : 0));
    chk("commit_count", 512'(n_cmt), 512'(exp_new ? 1 : 0));
    chk("ack_count", 512'(n_ack), 512'((exp_new || exp_dup) ? 1 : 0));
  endtask

  initial begin
    int c, k, nb;
    logic [31:0] s;
    logic [7:0] ty;

    rst_n = 1'b0;
    quiet_inputs();
    nb_tdata = '0; nb_tkeep = '0; nb_tuser = '0; wr_tdata = '0;
    for (int i = 0; i < 8; i++) wnn_mem[i] = $urandom;
    repeat (3) @(negedge clk);
    chk("reset_nb_ready", 512'(nb_tready), 512'(1));
    chk("reset_wnn_ready", 512'(wr_tready), 512'(0));
    chk("reset_valids", 512'({wq_tvalid, c_tvalid, a_tvalid}), 512'(0));
    chk("reset_ctrl_data", c_tdata, 512'(0));
    chk("reset_wnn_dest", 512'(wq_tdest), 512'(0));
    rst_n = 1'b1;

    wnn_mem[3] = 32'd5;
    run_txn(8'h10, 3, 32'd6, 1, 0, 0);
    run_txn(8'h10, 3, 32'd6, 1, 0, 0);
    wnn_mem[3] = 32'd5;
    run_txn(8'h10, 3, 32'd9, 1, 0, 0);
    wnn_mem[4] = 32'hFFFF_FFFF;
    run_txn(8'h10, 4, 32'd0, 1, 0, 0);
    run_txn(8'h33, 2, 32'd7, 1, 0, 0);
    run_txn(8'h10, 1, wnn_mem[1] + 32'd1, 3, 0, 0);
    run_txn(8'h10, 6, wnn_mem[6] + 32'd1, 1, 10, 0);
    run_txn(8'h10, 6, wnn_mem[6], 1, 10, 0);
    run_txn(8'h10, 5, wnn_mem[5] + 32'd1, 1, 10, 1);
    run_txn(8'h10, 5, wnn_mem[5] + 32'd1, 1, 0, 0);

    for (int t = 0; t < 60; t++) begin
      c  = $urandom_range(0, 7);
      k  = $urandom_range(0, 9);
      ty = 8'h10;
      nb = 1;
      case (k)
        0, 1, 2, 3: s = wnn_mem[c] + 32'd1;
        4, 5:       s = wnn_mem[c];
        6:          s = wnn_mem[c] + 32'($urandom_range(2, 1000));
        7:          s = wnn_mem[c] - 32'($urandom_range(1, 1000));
        8: begin
          s  = $urandom;
          ty = 8'($urandom_range(0, 255));
          if (ty == 8'h10) ty = 8'h12;
        end
        default: begin
          s  = wnn_mem[c] + 32'd1;
          nb = $urandom_range(2, 4);
        end
      endcase
      run_txn(ty, c, s, nb, $urandom_range(0, 3), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rpn_kip_rx.md
# rpn_kip_rx

Receive-side reliability stage for KIP traffic; it is the remote peer of the KIP transmitter. It accepts single-beat PUB packets from the Network Bridge and looks up the last accepted WAN sequence number for the sender cluster in the WAN Number Node (WNN). New packets are delivered to the control path. Every PUB that is new or a duplicate gets a KIP ACK, so the transmitter stops retransmitting.

## Interface
Parameters:
- AXIS_DATA_WIDTH, 512, network beat width; AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8
- CTID_WIDTH, 16, cluster ID width
- SEQ_WIDTH, 32, WAN sequence number width
- KIP_TUSER_WIDTH, 64, {dst port[63:48], src port[47:32], IP[31:0]}

Ports:
- i_clk  in  1  clock
- i_ap_rst_n  in  1  reset; asynchronous, active-low; clock i_clk
- i_cluster_id  in  CTID_WIDTH  own cluster ID
- i_KIP_port_number  in  16  UDP port for ACKs
- from_nb_{tvalid,tready,tdata,tkeep,tuser,tlast}  in/out/in/in/in/in  1/1/AXIS_DATA_WIDTH/AXIS_KEEP_WIDTH/KIP_TUSER_WIDTH/1  PUB from Network Bridge
- to_WNN_{tvalid,tready,tdata,tdest}  out/in/out/out  1/1/8/CTID_WIDTH  seq lookup/commit
- from_WNN_{tvalid,tready,tdata}  in/out/in  1/1/SEQ_WIDTH  last accepted seq
- to_ctrl_{tvalid,tready,tdata,tkeep,tuser,tlast}  out/in/out/out/out/out  1/1/AXIS_DATA_WIDTH/AXIS_KEEP_WIDTH/CTID_WIDTH+32/1  delivered payload
- to_nb_KIP_{tvalid,tready,tdata,tkeep,tuser,tlast}  out/in/out/out/out/out  ACK to Network Bridge

## Operation
- PUB layout: [7:0] type; [23:8] sender CTID; [55:24] seq; [AXIS_DATA_WIDTH-1:56] payload.
- States: IDLE, DRAIN, REQ_WNN, WAIT_WNN, FWD_CTRL, COMMIT_WNN, SEND_ACK.
- IDLE: from_nb_tready=1. On a handshake, capture CTID, seq, payload, tkeep and tuser IP.
  - type==MSG_KIP_PUB with tlast=1 -> REQ_WNN.
  - tlast=0 (any type) -> DRAIN.
  - Any other type -> stay in IDLE (dropped).
- DRAIN: tready=1; consume beats until a tlast handshake, then IDLE. No ACK is sent.
- REQ_WNN: to_WNN_tvalid=1, tdata=MSG_SEQ_REQ, tdest=captured CTID. Go to WAIT_WNN on tready.
- WAIT_WNN: from_WNN_tready=1. On tvalid compute diff = (seq - last) mod 2^SEQ_WIDTH:
  - diff==1 (new) -> FWD_CTRL.
  - diff==0 (duplicate) -> SEND_ACK.
  - Otherwise (out of order) -> IDLE, no ACK.
- FWD_CTRL: to_ctrl_tvalid=1, tdata = payload zero-extended, tkeep = captured tkeep>>7, tuser = {CTID, IP}, tlast=1. Go to COMMIT_WNN on tready.
- COMMIT_WNN: to_WNN_tvalid=1, tdata=MSG_SEQ_COMMIT, tdest=CTID. Go to SEND_ACK on tready.
- SEND_ACK: to_nb_KIP_tvalid=1.
  - tdata: [7:0]=MSG_KIP_ACK, [23:8]=i_cluster_id, [55:24]=captured seq, rest 0.
  - tkeep = 7 low bits set; tuser = {port, port, captured IP}; tlast=1.
  - Go to IDLE on tready.
- Wrap: last=0xFFFFFFFF, seq=0 gives diff=1, so the packet is new.

## Timing
- Reset: state IDLE. All tvalid outputs 0, all captured registers 0. from_nb_tready=1 and from_WNN_tready=0 (both follow state).
- A reset mid-transaction abandons it with no ACK; the transmitter's retransmit recovers.
- Every tvalid/tready output is a pure decode of the registered state, with no input-to-output combinational paths on valid.
- Data outputs hold stable while tvalid=1 and tready=0.
- Best-case new PUB: 5 cycles from the IDLE handshake to the ACK handshake (REQ, WAIT, FWD, COMMIT, ACK each 1 cycle). Duplicate: 3 cycles.
- A from_WNN response outside WAIT_WNN is not accepted (tready=0).
- One transaction in flight; from_nb is back-pressured outside IDLE/DRAIN.

## Structure
- Package rpn_kip_pkg: MSG_KIP_PUB=8'h10, MSG_KIP_ACK=8'h11, MSG_SEQ_REQ=8'h20, MSG_SEQ_COMMIT=8'h21, PUB/ACK field offsets and widths, state enum.
- Single module. The ACK formatter is combinational inside the module; no sub-module.

## Test plan
- Last=5 from WNN, PUB seq=6 CTID=3 -> one to_ctrl beat with payload, then COMMIT tdest=3, then ACK with [23:8]=i_cluster_id and [55:24]=6.
- Last=6, PUB seq=6 -> no to_ctrl beat, no COMMIT, ACK with seq 6.
- Last=5, PUB seq=9 -> nothing emitted, returns to IDLE.
- Last=0xFFFFFFFF, PUB seq=0 -> delivered and ACKed.
- Non-PUB type, and a 3-beat packet with tlast on beat 3 -> all beats consumed, no outputs.
- to_ctrl_tready and to_nb_KIP_tready held low 10 cycles -> outputs stable.
- Reset asserted in FWD_CTRL -> all tvalid outputs 0 immediately.
